pll_reset_ctrl: RTL and testbench

Power-up and recovery sequencer for the system PLL, running from the free-running 50 MHz reference clock. It pulses the PLL reset, waits for lock with a timeout and retry, and requires lock to stay stable for a programmable interval before releasing the system reset. It re-runs the sequence on loss of lock or on an explicit relock request. It sits between the board reset and the PLL wrapper, and its `sys_rst` output drives the reset of every block clocked from the PLL outputs.

---
 rtl/pll_reset_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
// Power-up and recovery sequencer for the system PLL. The sequence is:
// pulse the PLL reset, wait for lock (with timeout and retry), require lock
// to hold for a programmable interval, then release the system reset. The
// sequence runs again on loss of lock or on an explicit relock request.
// Everything runs on the free-running reference clock.

module pll_reset_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_lost,
    output logic [7:0] retry_count,
    output logic [1:0] state
);

    // A single counter serves every state, so it is sized for the longest interval.
    localparam int MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic [7:0]             retry_reg;
    logic [7:0]             retry_next;
    logic                   lock_lost_reg;
    logic                   lock_lost_next;
    logic                   pll_rst_reg;
    logic                   sys_rst_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   locked_s;

    // pll_locked comes from the PLL's own timing domain; bring it in through a
    // two-flop chain before any decision is based on it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_reg[SYNC_STAGES-1];

    // Next-state, counter, retry and lock-loss decisions.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        retry_next     = retry_reg;
        lock_lost_next = 1'b0;

        case (state_reg)
            ST_RESET_PLL: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                // Lock arriving on the timeout cycle still counts as lock.
                if (locked_s) begin
                    state_next = ST_STABILIZE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = ST_RESET_PLL;
                    cnt_next   = CNT_ZERO;
                    if (retry_reg != 8'hFF) begin
                        retry_next = retry_reg + 8'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            ST_STABILIZE: begin
                // Any dropout restarts the wait, including one on the terminal count.
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    state_next     = ST_RESET_PLL;
                    cnt_next       = CNT_ZERO;
                    lock_lost_next = 1'b1;
                end
            end

            default: begin
                state_next = ST_RESET_PLL;
                cnt_next   = CNT_ZERO;
            end
        endcase

        // A relock request overrides everything and is not treated as a fault.
        if (relock_req) begin
            state_next     = ST_RESET_PLL;
            cnt_next       = CNT_ZERO;
            retry_next     = retry_reg;
            lock_lost_next = 1'b0;
        end
    end

    // State, counter and registered outputs; outputs are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg     <= ST_RESET_PLL;
            cnt_reg       <= CNT_ZERO;
            retry_reg     <= 8'd0;
            lock_lost_reg <= 1'b0;
            pll_rst_reg   <= 1'b1;
            sys_rst_reg   <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            lock_lost_reg <= lock_lost_next;
            pll_rst_reg   <= (state_next == ST_RESET_PLL);
            sys_rst_reg   <= (state_next != ST_RUN);
        end
    end

    assign pll_rst     = pll_rst_reg;
    assign sys_rst     = sys_rst_reg;
    assign lock_lost   = lock_lost_reg;
    assign retry_count = retry_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed testbench for pll_reset_ctrl with RST_CYCLES=4, STABLE_CYCLES=8,
// TIMEOUT_CYCLES=32. Outputs are sampled 1 time unit after each rising edge.

module tb_pll_reset_ctrl;

    localparam int RST_C = 4;
    localparam int ST_C  = 8;
    localparam int TO_C  = 32;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       lock_lost;
    logic [7:0] retry_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    pll_reset_ctrl #(
        .RST_CYCLES    (RST_C),
        .STABLE_CYCLES (ST_C),
        .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .lock_lost  (lock_lost),
        .retry_count(retry_count),
        .state      (state)
    );

    always #5 refclk = ~refclk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Hold reset for three edges, then release; the next edge is the first one out of reset.
    task automatic apply_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Bounded wait for a state value; the caller compares the result.
    task automatic wait_for_state(input logic [1:0] s, input int budget, output bit found);
        int n;
        found = 1'b0;
        n     = 0;
        while (!found && n < budget) begin
            tick();
            n++;
            if (state === s) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL reset_retry got %0d want 0", retry_count); end
        $display("test_reset done");
    endtask

    task automatic test_clean_bringup();
        int n;
        apply_reset();
        for (int i = 1; i < RST_C; i++) begin
            tick();
            checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL bringup_pll_rst_hi cycle %0d got %b want 1", i, pll_rst); end
        end
        tick();
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL bringup_pll_rst_lo got %b want 0", pll_rst); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL bringup_wait_state got %0d want 1", state); end
        repeat (6) tick();
        pll_locked = 1'b1;
        n = 0;
        while (sys_rst === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++; if (n != 2 + ST_C + 1) begin errors++; $display("FAIL bringup_sys_rst_delay got %0d want %0d", n, 2 + ST_C + 1); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL bringup_run_state got %0d want 3", state); end
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL bringup_run_pll_rst got %b want 0", pll_rst); end
        $display("test_clean_bringup done delay=%0d", n);
    endtask

    task automatic test_timeout_retry();
        int t;
        apply_reset();
        t = 0;
        while (t < 35) begin tick(); t++; end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL timeout_retry_before got %0d want 0", retry_count); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL timeout_state_before got %0d want 1", state); end
        tick(); t++;
        checks++; if (retry_count !== 8'd1) begin errors++; $display("FAIL timeout_retry_first got %0d want 1", retry_count); end
        checks++; if (state !== 2'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL timeout_back_to_reset got state %0d pll_rst %b want 0/1", state, pll_rst); end
        while (t < 39) begin tick(); t++; end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL timeout_reset_width got %0d want 0", state); end
        tick(); t++;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL timeout_rewait got %0d want 1", state); end
        while (t < 72) begin tick(); t++; end
        checks++; if (retry_count !== 8'd2) begin errors++; $display("FAIL timeout_retry_second got %0d want 2", retry_count); end
        while (t < 255 * 36 - 1) begin tick(); t++; end
        checks++; if (retry_count !== 8'd254) begin errors++; $display("FAIL timeout_retry_254 got %0d want 254", retry_count); end
        tick(); t++;
        checks++; if (retry_count !== 8'd255) begin errors++; $display("FAIL timeout_retry_255 got %0d want 255", retry_count); end
        repeat (100) tick();
        checks++; if (retry_count !== 8'd255) begin errors++; $display("FAIL timeout_saturate got %0d want 255", retry_count); end
        $display("test_timeout_retry done retry=%0d", retry_count);
    endtask

    task automatic test_lock_wins_timeout();
        apply_reset();
        repeat (33) tick();
        pll_locked = 1'b1;
        repeat (2) tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL lockwin_pre_state got %0d want 1", state); end
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL lockwin_state got %0d want 2", state); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL lockwin_retry got %0d want 0", retry_count); end
        $display("test_lock_wins_timeout done");
    endtask

    task automatic test_stabilize_glitch();
        bit found;
        apply_reset();
        pll_locked = 1'b1;
        wait_for_state(2'd2, 20, found);
        checks++; if (!found) begin errors++; $display("FAIL glitch_reach_stab got state %0d want 2", state); end
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_still_stab got %0d want 2", state); end
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_back_wait got %0d want 1", state); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL glitch_sys_rst got %b want 1", sys_rst); end
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_restab got %0d want 2", state); end
        repeat (ST_C - 1) tick();
        checks++; if (sys_rst !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL glitch_full_window got sys_rst %b state %0d want 1/2", sys_rst, state); end
        tick();
        checks++; if (sys_rst !== 1'b0 || state !== 2'd3) begin errors++; $display("FAIL glitch_run got sys_rst %b state %0d want 0/3", sys_rst, state); end
        $display("test_stabilize_glitch done");
    endtask

    task automatic test_loss_in_run();
        bit found;
        apply_reset();
        repeat (72) tick();
        checks++; if (retry_count !== 8'd2) begin errors++; $display("FAIL loss_setup_retry got %0d want 2", retry_count); end
        pll_locked = 1'b1;
        wait_for_state(2'd3, 60, found);
        checks++; if (!found) begin errors++; $display("FAIL loss_reach_run got state %0d want 3", state); end
        pll_locked = 1'b0;
        repeat (2) tick();
        checks++; if (state !== 2'd3 || sys_rst !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL loss_sync_delay got state %0d sys_rst %b lock_lost %b want 3/0/0", state, sys_rst, lock_lost); end
        tick();
        checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_pulse got %b want 1", lock_lost); end
        checks++; if (sys_rst !== 1'b1 || pll_rst !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL loss_resets got sys_rst %b pll_rst %b state %0d want 1/1/0", sys_rst, pll_rst, state); end
        pll_locked = 1'b1;
        tick();
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL loss_pulse_end got %b want 0", lock_lost); end
        repeat (2) tick();
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst_width got %b want 1", pll_rst); end
        tick();
        checks++; if (pll_rst !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL loss_pll_rst_end got pll_rst %b state %0d want 0/1", pll_rst, state); end
        wait_for_state(2'd3, 40, found);
        checks++; if (!found) begin errors++; $display("FAIL loss_relock_run got state %0d want 3", state); end
        checks++; if (retry_count !== 8'd2) begin errors++; $display("FAIL loss_retry_kept got %0d want 2", retry_count); end
        $display("test_loss_in_run done");
    endtask

    task automatic test_relock_req();
        bit found;
        bit saw_lost;
        saw_lost = 1'b0;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++; if (state !== 2'd0 || pll_rst !== 1'b1 || sys_rst !== 1'b1) begin errors++; $display("FAIL relock_run got state %0d pll_rst %b sys_rst %b want 0/1/1", state, pll_rst, sys_rst); end
        if (lock_lost === 1'b1) saw_lost = 1'b1;
        repeat (2) begin tick(); if (lock_lost === 1'b1) saw_lost = 1'b1; end
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        if (lock_lost === 1'b1) saw_lost = 1'b1;
        checks++; if (state !== 2'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL relock_mid_reset got state %0d pll_rst %b want 0/1", state, pll_rst); end
        repeat (3) begin tick(); if (lock_lost === 1'b1) saw_lost = 1'b1; end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL relock_restart_width got %b want 1", pll_rst); end
        tick();
        checks++; if (pll_rst !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL relock_pulse_end got pll_rst %b state %0d want 0/1", pll_rst, state); end
        checks++; if (saw_lost) begin errors++; $display("FAIL relock_no_lock_lost got 1 want 0"); end
        wait_for_state(2'd3, 40, found);
        checks++; if (!found) begin errors++; $display("FAIL relock_back_run got state %0d want 3", state); end
        checks++; if (retry_count !== 8'd2) begin errors++; $display("FAIL relock_retry_kept got %0d want 2", retry_count); end
        $display("test_relock_req done");
    endtask

    task automatic test_mid_reset();
        bit found;
        apply_reset();
        repeat (108) tick();
        checks++; if (retry_count !== 8'd3) begin errors++; $display("FAIL midrst_setup_retry got %0d want 3", retry_count); end
        pll_locked = 1'b1;
        wait_for_state(2'd2, 60, found);
        checks++; if (!found) begin errors++; $display("FAIL midrst_reach_stab got state %0d want 2", state); end
        rst = 1'b1;
        tick();
        checks++; if (state !== 2'd0 || pll_rst !== 1'b1 || sys_rst !== 1'b1 || lock_lost !== 1'b0) begin errors++; $display("FAIL midrst_outputs got state %0d pll_rst %b sys_rst %b lock_lost %b want 0/1/1/0", state, pll_rst, sys_rst, lock_lost); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL midrst_retry got %0d want 0", retry_count); end
        rst = 1'b0;
        repeat (RST_C - 1) tick();
        checks++; if (pll_rst !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL midrst_restart_hi got pll_rst %b state %0d want 1/0", pll_rst, state); end
        tick();
        checks++; if (pll_rst !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL midrst_restart_wait got pll_rst %b state %0d want 0/1", pll_rst, state); end
        wait_for_state(2'd3, 40, found);
        checks++; if (!found || retry_count !== 8'd0) begin errors++; $display("FAIL midrst_run got state %0d retry %0d want 3/0", state, retry_count); end
        $display("test_mid_reset done");
    endtask

    initial begin
        test_reset();
        test_clean_bringup();
        test_timeout_retry();
        test_lock_wins_timeout();
        test_stabilize_glitch();
        test_loss_in_run();
        test_relock_req();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
